// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states, counter sizing.
// Signed arithmetic is compiled in only when ALU_SIGNED_EN is defined.
package seq_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle of the sequential ALU; the sgn field exists only with ALU_SIGNED_EN.
interface seq_alu_if #(parameter int w = 8);

    logic [w-1:0]   x;
    logic [w-1:0]   y;
    logic [1:0]     op;
    logic           start;
`ifdef ALU_SIGNED_EN
    logic           sgn;
`endif
    logic [2*w-1:0] z;
    logic           done;
    logic           busy;
    logic           dz;

    modport master (
        output x, y, op, start,
`ifdef ALU_SIGNED_EN
        output sgn,
`endif
        input  z, done, busy, dz
    );

    modport slave (
        input  x, y, op, start,
`ifdef ALU_SIGNED_EN
        input  sgn,
`endif
        output z, done, busy, dz
    );

endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned datapath: one shift-add (mul) or restoring-subtract (div) step per enable.
// {hi, lo} holds the product, or remainder (hi) and quotient (lo) once all steps are done.
module alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] hi,
    output logic [w-1:0] lo
);

    logic [w-1:0] b_r;
    logic [w:0]   sum;
    logic [w:0]   shifted;
    logic [w:0]   diff;
    logic         ge;

    assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
    assign shifted = {hi, lo[w-1]};
    assign diff    = shifted - {1'b0, b_r};
    // The partial remainder stays below 2*b, so a set top bit means the trial subtract borrowed.
    assign ge      = ~diff[w];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            b_r <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a;
            b_r <= b;
        end else if (step) begin
            if (is_div) begin
                hi <= ge ? diff[w-1:0] : shifted[w-1:0];
                lo <= {lo[w-2:0], ge};
            end else begin
                hi <= sum[w:1];
                lo <= {sum[0], lo[w-1:1]};
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU top: FSM, iteration counter, sign handling and result registers.
// Define ALU_SIGNED_EN to add the sgn input and two's-complement arithmetic.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int w = 8
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);

    localparam int CW = cnt_bits(w);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic           load;
    logic           step;
    logic           fin;
    logic           fast_wr;
    logic           fast_dz;
    logic [2*w-1:0] fast_z;
    logic [2*w-1:0] fin_z;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic           sgn_in;
    logic           x_neg;
    logic           y_neg;
    logic [w-1:0]   x_mag;
    logic [w-1:0]   y_mag;
    logic [w-1:0]   hi;
    logic [w-1:0]   lo;
    logic [w-1:0]   q_out;
    logic [w-1:0]   r_out;
    logic [2*w-1:0] x_ext;
    logic [2*w-1:0] y_ext;
    logic [2*w-1:0] prod;

`ifdef ALU_SIGNED_EN
    assign sgn_in = bus.sgn;
`else
    assign sgn_in = 1'b0;
`endif

    assign x_neg = sgn_in & bus.x[w-1];
    assign y_neg = sgn_in & bus.y[w-1];
    assign x_mag = x_neg ? -bus.x : bus.x;
    assign y_mag = y_neg ? -bus.y : bus.y;
    assign x_ext = {{w{x_neg}}, bus.x};
    assign y_ext = {{w{y_neg}}, bus.y};

    alu_muldiv #(.w(w)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .is_div (is_div),
        .a      (x_mag),
        .b      (y_mag),
        .hi     (hi),
        .lo     (lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        fast_wr   = 1'b0;
        fast_dz   = 1'b0;
        fast_z    = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_ADD: begin
                            fast_wr = 1'b1;
                            fast_z  = x_ext + y_ext;
                        end
                        OP_SUB: begin
                            fast_wr = 1'b1;
                            fast_z  = x_ext - y_ext;
                        end
                        OP_MUL: begin
                            load      = 1'b1;
                            state_nxt = RUN;
                        end
                        default: begin
                            if (bus.y == '0) begin
                                fast_wr = 1'b1;
                                fast_dz = 1'b1;
                                fast_z  = {bus.x, {w{1'b1}}};
                            end else begin
                                load      = 1'b1;
                                state_nxt = RUN;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(w - 1)) state_nxt = FIN;
            end
            FIN: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result signs are captured at launch because the operands may change during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            is_div <= (bus.op == OP_DIV);
            neg_q  <= x_neg ^ y_neg;
            neg_r  <= x_neg;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign prod  = {hi, lo};
    assign q_out = neg_q ? -lo : lo;
    assign r_out = neg_r ? -hi : hi;
    assign fin_z = is_div ? {r_out, q_out} : (neg_q ? -prod : prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.z    <= '0;
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
        end else begin
            bus.done <= fast_wr | fin;
            if (fast_wr) begin
                bus.z  <= fast_z;
                bus.dz <= fast_dz;
            end else if (fin) begin
                bus.z  <= fin_z;
                bus.dz <= 1'b0;
            end
        end
    end

    assign bus.busy = (state != IDLE);

endmodule
